// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - start/stop/lap/clear stopwatch with csec/sec/min cascade
// Optional: define STOPWATCH_SATURATE_EN to stop at 59:59.99 instead of wrapping.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int TICK_W   = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start_stop,
  input  logic       i_lap,
  input  logic       i_clear,
  output logic [6:0] o_csec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic       o_running,
  output logic       o_lap_frozen,
  output logic       o_wrap
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_PAUSE} state_e;

  state_e            state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic [6:0]        csec_q, csec_d, lap_csec_q, lap_csec_d;
  logic [5:0]        sec_q, sec_d, lap_sec_q, lap_sec_d;
  logic [5:0]        min_q, min_d, lap_min_q, lap_min_d;
  logic              wrap_q, wrap_d;
  logic              counting, tick, at_max, sat_hit, sat_block;

  assign counting = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick     = counting && (presc_q == TICK_W'(TICK_DIV - 1));
  assign at_max   = (csec_q == 7'd99) && (sec_q == 6'd59) && (min_q == 6'd59);

`ifdef STOPWATCH_SATURATE_EN
  logic sat_q, sat_d;
  assign sat_hit   = tick && at_max;
  assign sat_block = sat_q;
  assign sat_d     = i_clear ? 1'b0 : (sat_q | sat_hit);
  always_ff @(posedge clk) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end
`else
  assign sat_hit   = 1'b0;
  assign sat_block = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      csec_q     <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      lap_csec_q <= '0;
      lap_sec_q  <= '0;
      lap_min_q  <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      csec_q     <= csec_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      lap_csec_q <= lap_csec_d;
      lap_sec_q  <= lap_sec_d;
      lap_min_q  <= lap_min_d;
      wrap_q     <= wrap_d;
    end
  end

  // Priority: clear > limit reached > start_stop > lap.
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = S_IDLE;
    end else if (sat_hit) begin
      state_d = S_PAUSE;
    end else begin
      case (state_q)
        S_IDLE:  if (i_start_stop) state_d = S_RUN;
        S_RUN:   if (i_start_stop) state_d = S_PAUSE;
                 else if (i_lap)   state_d = S_LAP;
        S_LAP:   if (i_start_stop) state_d = S_PAUSE;
                 else if (i_lap)   state_d = S_RUN;
        S_PAUSE: if (i_start_stop && !sat_block) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    presc_d    = presc_q;
    csec_d     = csec_q;
    sec_d      = sec_q;
    min_d      = min_q;
    lap_csec_d = lap_csec_q;
    lap_sec_d  = lap_sec_q;
    lap_min_d  = lap_min_q;
    wrap_d     = 1'b0;
    if (i_clear) begin
      presc_d    = '0;
      csec_d     = '0;
      sec_d      = '0;
      min_d      = '0;
      lap_csec_d = '0;
      lap_sec_d  = '0;
      lap_min_d  = '0;
    end else begin
      if (tick) begin
        presc_d = '0;
        wrap_d  = at_max;
        if (!sat_hit) begin
          if (csec_q == 7'd99) begin
            csec_d = '0;
            if (sec_q == 6'd59) begin
              sec_d = '0;
              min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end else begin
            csec_d = csec_q + 7'd1;
          end
        end
      end else if (counting) begin
        presc_d = presc_q + TICK_W'(1);
      end
      // Latch the pre-tick registered value on entry to LAP.
      if (state_q == S_RUN && state_d == S_LAP) begin
        lap_csec_d = csec_q;
        lap_sec_d  = sec_q;
        lap_min_d  = min_q;
      end
    end
  end

  always_comb begin
    o_lap_frozen = (state_q == S_LAP);
    o_running    = counting;
    o_wrap       = wrap_q;
    o_csec       = o_lap_frozen ? lap_csec_q : csec_q;
    o_sec        = o_lap_frozen ? lap_sec_q  : sec_q;
    o_min        = o_lap_frozen ? lap_min_q  : min_q;
  end

endmodule
